// File: rtl/z3_pkg.sv
// Shared definitions for the Zorro III bus initiator.
// Holds the cycle state encoding, the default function code and the idle
// (deasserted) levels of the active-low strobes so that the master and any
// future slave-side logic agree on them.
package z3_pkg;

  // Phases of one complete Zorro III initiator cycle
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_TERM    = 3'd4,
    ST_RECOVER = 3'd5
  } z3_state_e;

  // Supervisor data space
  localparam logic [2:0] Z3_DEF_FC = 3'b101;

  // Deasserted levels of the active-low strobes
  localparam logic       FCS_IDLE = 1'b1;
  localparam logic [3:0] DS_IDLE  = 4'hF;

endpackage

// File: rtl/z3_sync2.sv
// Two-flop synchronizer for an asynchronous active-low bus line.
// Ports:
//   i_clk - bus clock
//   i_rst - synchronous active-high reset, forces both stages to 1 (idle)
//   i_d   - asynchronous input
//   o_q   - synchronized output (second stage)
module z3_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset to 1 so a released (high) bus line looks idle straight out of reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/z3_bus_master.sv
// Zorro III bus initiator: turns one local single-word request into a full
// Z3 cycle (address phase, FCS_n, data phase with DOE/DS_n) and terminates
// it on DTACK_n, BERR_n or a local timeout.  Pad tristating lives above.
// Ports:
//   CLK, RST                - clock, synchronous active-high reset
//   req/we/addr/wdata/be    - local request, sampled only while idle
//   ack/err/rdata/busy      - local completion pulse, error flag, read data, busy
//   AD_out/AD_oe/AD_in      - multiplexed address/data bus drive and receive
//   FC/FCS_n/DS_n/READ/DOE  - Z3 control outputs
//   DTACK_n/BERR_n          - asynchronous slave responses
module z3_bus_master
  import z3_pkg::*;
#(
  parameter int         ADDR_SETUP = 2,
  parameter int         TIMEOUT    = 255,
  parameter logic [2:0] DEF_FC     = Z3_DEF_FC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] AD_out,
  output logic        AD_oe,
  input  logic [31:0] AD_in,
  output logic [2:0]  FC,
  output logic        FCS_n,
  output logic [3:0]  DS_n,
  output logic        READ,
  output logic        DOE,
  input  logic        DTACK_n,
  input  logic        BERR_n
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP + 1) : 1;
  localparam logic [CW-1:0] TO_VAL     = CW'(TIMEOUT);
  localparam logic [SW-1:0] SETUP_LOAD = SW'(ADDR_SETUP - 1);

  z3_state_e     r_state;
  logic [SW-1:0] r_setup;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;

  logic          w_dtackS;
  logic          w_berrS;
  logic [CW-1:0] w_cntNext;
  logic          w_termNow;
  logic          w_termErr;

  z3_sync2 u_syncDtack (.i_clk(CLK), .i_rst(RST), .i_d(DTACK_n), .o_q(w_dtackS));
  z3_sync2 u_syncBerr  (.i_clk(CLK), .i_rst(RST), .i_d(BERR_n),  .o_q(w_berrS));

  assign w_cntNext = r_cnt + 1'b1;

  // Termination decision while waiting: BERR beats DTACK, DTACK beats a
  // timeout expiring on the same edge.
  always_comb begin
    w_termNow = 1'b0;
    w_termErr = 1'b0;
    if (!w_berrS) begin
      w_termNow = 1'b1;
      w_termErr = 1'b1;
    end else if (!w_dtackS) begin
      w_termNow = 1'b1;
    end else if (w_cntNext == TO_VAL) begin
      w_termNow = 1'b1;
      w_termErr = 1'b1;
    end
  end

  // Cycle sequencer.  Every bus output is registered here; the termination
  // values are loaded on the edge that enters TERM so that ack is high for
  // exactly the TERM cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_setup <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      AD_out  <= '0;
      AD_oe   <= 1'b0;
      FC      <= 3'b000;
      FCS_n   <= FCS_IDLE;
      DS_n    <= DS_IDLE;
      READ    <= 1'b1;
      DOE     <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_wdata <= wdata;
            r_be    <= be;
            AD_out  <= {addr, 2'b00};
            AD_oe   <= 1'b1;
            READ    <= ~we;
            FC      <= DEF_FC;
            r_setup <= SETUP_LOAD;
            busy    <= 1'b1;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (r_setup == '0) begin
            FCS_n   <= 1'b0;
            r_state <= ST_STROBE;
          end else begin
            r_setup <= r_setup - 1'b1;
          end
        end
        ST_STROBE: begin
          // Reads release the bus to the slave; writes put data on it
          if (r_we) begin
            AD_out <= r_wdata;
          end else begin
            AD_oe <= 1'b0;
          end
          DOE     <= 1'b1;
          DS_n    <= ~r_be;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_termNow) begin
            FCS_n   <= FCS_IDLE;
            DS_n    <= DS_IDLE;
            DOE     <= 1'b0;
            AD_oe   <= 1'b0;
            READ    <= 1'b1;
            FC      <= 3'b000;
            ack     <= 1'b1;
            err     <= w_termErr;
            r_cnt   <= '0;
            r_state <= ST_TERM;
            if (!r_we && !w_termErr) begin
              rdata <= AD_in;
            end
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        ST_TERM: begin
          r_state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          // Leave once the slave lets go, or give up on a stuck line
          if ((w_dtackS && w_berrS) || (w_cntNext == TO_VAL)) begin
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z3_bus_master.sv
// Self-checking bench for z3_bus_master with a small behavioural Z3 slave.
`timescale 1ns/1ps
module tb_z3_bus_master;

  localparam int         ADDR_SETUP = 2;
  localparam int         TIMEOUT    = 8;
  localparam logic [2:0] DEF_FC     = 3'b101;

  logic        CLK = 1'b0;
  logic        RST, req, we, ack, err, busy, AD_oe, FCS_n, READ, DOE, DTACK_n, BERR_n;
  logic [29:0] addr;
  logic [31:0] wdata, rdata, AD_out, AD_in;
  logic [3:0]  be, DS_n;
  logic [2:0]  FC;

  z3_bus_master #(.ADDR_SETUP(ADDR_SETUP), .TIMEOUT(TIMEOUT), .DEF_FC(DEF_FC)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .AD_out(AD_out), .AD_oe(AD_oe), .AD_in(AD_in), .FC(FC), .FCS_n(FCS_n),
    .DS_n(DS_n), .READ(READ), .DOE(DOE), .DTACK_n(DTACK_n), .BERR_n(BERR_n)
  );

  always #5 CLK = ~CLK;

  typedef enum int {R_NONE, R_DTACK, R_BERR, R_BOTH} resp_e;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    resp_e       resp;
    int          delay;
    logic [31:0] slaveData;
    logic        expErr;
    logic [31:0] expRdata;
  } txn_t;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] modelRdata = '0;
  txn_t        vecs[8];

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: a slave only answers when a strobe is active and answers
  // before the timeout; otherwise the master reports an error.
  function automatic txn_t modelTxn(input txn_t t, input logic [31:0] prevRdata);
    txn_t r = t;
    bit responds = (t.resp != R_NONE) && (t.be != 4'h0);
    r.expErr   = !responds || (t.resp == R_BERR) || (t.resp == R_BOTH);
    r.expRdata = (responds && !t.we && t.resp == R_DTACK) ? t.slaveData : prevRdata;
    return r;
  endfunction

  // Drive one request and act as the slave, checking each phase as it passes.
  // Cycle n means n edges after the edge that samples req.
  task automatic applyStimulus(input txn_t t);
    int   s, ackCyc, busyLow;
    bit   responds, ackEarly;
    logic expRead;
    logic [3:0] expDs;
    s        = ADDR_SETUP + 1;
    responds = (t.resp != R_NONE) && (t.be != 4'h0);
    // Response needs two sync flops plus one decision edge
    ackCyc   = responds ? s + t.delay + 3 : s + TIMEOUT;
    busyLow  = responds ? ackCyc + 3 : ackCyc + 2;
    ackEarly = 1'b0;
    expRead  = ~t.we;
    expDs    = ~t.be;
    @(posedge CLK); #1;
    req = 1'b1; we = t.we; addr = t.addr; wdata = t.wdata; be = t.be; AD_in = ~t.slaveData;
    for (int n = 0; n <= busyLow; n++) begin
      @(posedge CLK); #1;
      if (n == 0) begin
        checkOutput("addrPhaseAD", AD_out, {t.addr, 2'b00});
        checkOutput("addrPhaseOe", AD_oe, 1);
        checkOutput("addrPhaseRead", READ, expRead);
        checkOutput("addrPhaseFc", FC, DEF_FC);
        checkOutput("busyStart", busy, 1);
      end
      if (n == ADDR_SETUP - 1) checkOutput("fcsSetupHigh", FCS_n, 1);
      if (n == ADDR_SETUP) begin
        checkOutput("fcsFall", FCS_n, 0);
        checkOutput("dsBeforeStrobe", DS_n, 4'hF);
      end
      if (n == s) begin
        checkOutput("doeStrobe", DOE, 1);
        checkOutput("dsStrobe", DS_n, expDs);
        checkOutput("adOeData", AD_oe, t.we);
        checkOutput("adData", AD_out, t.we ? t.wdata : {t.addr, 2'b00});
      end
      if (n < ackCyc && ack) ackEarly = 1'b1;
      if (n == ackCyc) begin
        checkOutput("ack", ack, 1);
        checkOutput("err", err, t.expErr);
        checkOutput("termFcs", FCS_n, 1);
        checkOutput("termDs", DS_n, 4'hF);
        checkOutput("termDoe", DOE, 0);
        checkOutput("termAdOe", AD_oe, 0);
        req = 1'b0; DTACK_n = 1'b1; BERR_n = 1'b1;
      end
      if (n == ackCyc + 1) checkOutput("ackOneCycle", ack, 0);
      if (n == busyLow - 1) checkOutput("busyHold", busy, 1);
      if (n == busyLow) checkOutput("busyFall", busy, 0);
      if (responds && n == s + t.delay) begin
        AD_in = t.slaveData;
        if (t.resp == R_DTACK || t.resp == R_BOTH) DTACK_n = 1'b0;
        if (t.resp == R_BERR  || t.resp == R_BOTH) BERR_n  = 1'b0;
      end
    end
    checkOutput("ackEarly", ackEarly, 0);
    checkOutput("rdata", rdata, t.expRdata);
    modelRdata = t.expRdata;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   ackCount, gap, gapDone, idleSeen;
    txn_t t;

    vecs[0] = '{1'b0, 30'h0400_0010, 32'h0,         4'hF,    R_DTACK, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 30'h0123_4567, 32'h12345678,  4'b0011, R_DTACK, 1, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 30'h0000_0100, 32'h0,         4'hF,    R_BOTH,  0, 32'hCAFEF00D, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 30'h0000_0200, 32'h0,         4'hF,    R_NONE,  0, 32'h11111111, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 30'h0000_0300, 32'h0,         4'h0,    R_DTACK, 0, 32'h22222222, 1'b1, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 30'h0000_0400, 32'h0,         4'hF,    R_BERR,  2, 32'h33333333, 1'b1, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 30'h0000_0500, 32'h0,         4'hF,    R_DTACK, 5, 32'h0BADF00D, 1'b0, 32'h0BADF00D};
    vecs[7] = '{1'b1, 30'h3FFF_FFFF, 32'hA5A5_5A5A, 4'b1000, R_DTACK, 0, 32'h0,        1'b0, 32'h0BADF00D};

    RST = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = 4'hF;
    AD_in = '0; DTACK_n = 1'b1; BERR_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rstFcs", FCS_n, 1);
    checkOutput("rstDs", DS_n, 4'hF);
    checkOutput("rstDoe", DOE, 0);
    checkOutput("rstAdOe", AD_oe, 0);
    checkOutput("rstRead", READ, 1);
    checkOutput("rstFc", FC, 0);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstRdata", rdata, 0);
    checkOutput("rstBusy", busy, 0);
    req = 1'b0; RST = 1'b0;
    @(posedge CLK); #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] reset during WAIT");
    @(posedge CLK); #1;
    req = 1'b1; we = 1'b0; addr = 30'h0000_0777; be = 4'hF;
    for (int n = 0; n <= ADDR_SETUP + 3; n++) @(posedge CLK);
    #1;
    checkOutput("dsAssertedInWait", DS_n, 4'h0);
    RST = 1'b1; req = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    checkOutput("midRstFcs", FCS_n, 1);
    checkOutput("midRstDs", DS_n, 4'hF);
    checkOutput("midRstDoe", DOE, 0);
    checkOutput("midRstAdOe", AD_oe, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstRdata", rdata, 0);
    modelRdata = '0;
    ackCount = 0;
    for (int n = 0; n < 3 * TIMEOUT; n++) begin
      @(posedge CLK); #1;
      if (ack) ackCount++;
    end
    checkOutput("midRstNoAck", ackCount, 0);

    $display("[TB] back-to-back requests");
    req = 1'b1; we = 1'b0; addr = 30'h0000_0888; be = 4'hF; AD_in = 32'h5555AAAA;
    ackCount = 0; gap = 0; gapDone = 0; idleSeen = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge CLK); #1;
      if (ack) begin
        ackCount++;
        if (ackCount == 2) req = 1'b0;
      end
      if (ackCount == 1 && gapDone == 0) begin
        if (FCS_n) gap++;
        else gapDone = 1;
        if (!busy) idleSeen = 1;
      end
      DTACK_n = (DS_n == 4'hF);
    end
    DTACK_n = 1'b1;
    checkOutput("b2bAckCount", ackCount, 2);
    checkOutput("b2bFcsGapAtLeast2", (gap >= 2) ? 1 : 0, 1);
    checkOutput("b2bIdleBetween", idleSeen, 1);
    checkOutput("b2bRdata", rdata, 32'h5555AAAA);
    modelRdata = 32'h5555AAAA;
    repeat (4) @(posedge CLK);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 24; i++) begin
      t.we        = 1'($urandom_range(0, 1));
      t.addr      = 30'($urandom);
      t.wdata     = $urandom;
      t.be        = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      t.resp      = resp_e'($urandom_range(0, 3));
      t.delay     = $urandom_range(0, TIMEOUT - 3);
      t.slaveData = $urandom;
      t.expErr    = 1'b0;
      t.expRdata  = '0;
      t = modelTxn(t, modelRdata);
      applyStimulus(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
